// File: rtl/fc_layer_engine.sv
// ---------------------------------------------------------------------------
// fc_layer_engine
//
// Fully-connected layer engine. It streams an IN_LEN-element signed input
// vector against a banked weight memory and runs OUT_CH parallel MAC lanes,
// one neuron per lane. The sequence repeats for NUM_TILES tiles. At the end of
// each tile the lane accumulators are requantised:
//   (acc * COEFF + 2^(SHIFT-1)) >>> SHIFT
// then an optional ReLU is applied and the result is saturated to DATA_WIDTH.
// One packed OUT_CH-lane word is emitted per tile.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      start pulse, sampled only while idle
//   relu_en_i    ReLU mode, latched when start_i is accepted
//   x_addr_o     input buffer address (k)
//   x_en_o       input buffer read enable
//   x_data_i     input element, valid one cycle after x_en_o
//   w_addr_o     weight address, tile*IN_LEN + k
//   w_en_o       weight read enable
//   w_data_i     weight word; lane j at [j*DATA_WIDTH +: DATA_WIDTH];
//                valid one cycle after w_en_o
//   out_data_o   packed saturated results, same lane packing as w_data_i
//   out_valid_o  one-cycle pulse per tile
//   out_tile_o   tile index belonging to out_data_o
//   busy_o       high whenever the engine is not idle
//   done_o       one-cycle pulse together with the last out_valid_o
// ---------------------------------------------------------------------------
module fc_layer_engine #(
  parameter int          DATA_WIDTH = 8,
  parameter int          IN_LEN     = 64,
  parameter int          OUT_CH     = 16,
  parameter int          NUM_TILES  = 1,
  parameter int          COEFF_W    = 17,
  parameter int unsigned COEFF      = 351,
  parameter int          SHIFT      = 12,
  parameter int          ACC_W      = 2*DATA_WIDTH + $clog2(IN_LEN)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                relu_en_i,
  output logic [$clog2(IN_LEN)-1:0]           x_addr_o,
  output logic                                x_en_o,
  input  logic [DATA_WIDTH-1:0]               x_data_i,
  output logic [$clog2(IN_LEN*NUM_TILES)-1:0] w_addr_o,
  output logic                                w_en_o,
  input  logic [OUT_CH*DATA_WIDTH-1:0]        w_data_i,
  output logic [OUT_CH*DATA_WIDTH-1:0]        out_data_o,
  output logic                                out_valid_o,
  output logic [$clog2(NUM_TILES):0]          out_tile_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int KW  = $clog2(IN_LEN);
  localparam int WAW = $clog2(IN_LEN*NUM_TILES);
  localparam int TW  = $clog2(NUM_TILES) + 1;
  localparam int PW  = ACC_W + COEFF_W + 2;   // product plus headroom for rounding

  localparam logic [KW-1:0]         K_LAST  = KW'(IN_LEN - 1);
  localparam logic [TW-1:0]         T_LAST  = TW'(NUM_TILES - 1);
  localparam logic [COEFF_W-1:0]    COEFF_U = COEFF_W'(COEFF);
  localparam logic signed [PW-1:0]  COEF_S  = signed'(PW'(COEFF_U));
  localparam logic signed [PW-1:0]  RND     = signed'(PW'(1) << (SHIFT - 1));
  localparam logic signed [PW-1:0]  SAT_MAX = PW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0]  SAT_MIN = -PW'(2 ** (DATA_WIDTH - 1));

  typedef enum logic [1:0] {IDLE, RUN, WAIT, QUANT} state_t;

  state_t                  state, next_state;
  logic [KW-1:0]           k;
  logic [TW-1:0]           tile;
  logic                    relu_q;
  logic                    vld_p1;
  logic                    clr_acc;
  logic signed [DATA_WIDTH-1:0]   x_p1;
  logic signed [DATA_WIDTH-1:0]   w_p1    [OUT_CH];
  logic signed [2*DATA_WIDTH-1:0] prod_p1 [OUT_CH];
  logic signed [ACC_W-1:0]        acc_p2  [OUT_CH];

  // acc * COEFF (signed * unsigned), then round-half-up arithmetic shift.
  function automatic logic signed [PW-1:0] rescale(input logic signed [ACC_W-1:0] acc);
    logic signed [PW-1:0] prod;
    prod = PW'(acc) * COEF_S;
    return (prod + RND) >>> SHIFT;
  endfunction

  // Optional ReLU, then clamp into the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] sat_relu(input logic signed [PW-1:0] val,
                                                     input logic relu);
    logic signed [PW-1:0] r;
    r = val;
    if (relu && (r < 0))
      r = '0;
    if (r > SAT_MAX)
      r = SAT_MAX;
    else if (r < SAT_MIN)
      r = SAT_MIN;
    return r[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    x_en_o     = 1'b0;
    w_en_o     = 1'b0;
    x_addr_o   = '0;
    w_addr_o   = '0;
    busy_o     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start_i)
          next_state = RUN;
      end
      RUN: begin
        x_en_o   = 1'b1;
        w_en_o   = 1'b1;
        x_addr_o = k;
        w_addr_o = WAW'(tile) * WAW'(IN_LEN) + WAW'(k);
        if (k == K_LAST)
          next_state = WAIT;
      end
      WAIT: begin
        next_state = QUANT;
      end
      QUANT: begin
        next_state = (tile == T_LAST) ? IDLE : RUN;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Lane accumulators restart on every entry into RUN (new run or next tile).
  assign clr_acc = (next_state == RUN) && (state != RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k           <= '0;
      tile        <= '0;
      relu_q      <= 1'b0;
      vld_p1      <= 1'b0;
      out_valid_o <= 1'b0;
      done_o      <= 1'b0;
      out_tile_o  <= '0;
    end else begin
      vld_p1      <= x_en_o;
      out_valid_o <= (state == QUANT);
      done_o      <= (state == QUANT) && (tile == T_LAST);
      if (state == RUN)
        k <= (k == K_LAST) ? '0 : k + 1'b1;
      else
        k <= '0;
      if ((state == IDLE) && start_i) begin
        tile   <= '0;
        relu_q <= relu_en_i;
      end else if ((state == QUANT) && (tile != T_LAST)) begin
        tile <= tile + 1'b1;
      end
      if (state == QUANT)
        out_tile_o <= tile;
    end
  end

  // ---- p1: memory read data arrives, lane products ----
  assign x_p1 = signed'(x_data_i);

  always_comb begin
    for (int j = 0; j < OUT_CH; j++) begin
      w_p1[j]    = signed'(w_data_i[j*DATA_WIDTH +: DATA_WIDTH]);
      prod_p1[j] = (2*DATA_WIDTH)'(x_p1) * (2*DATA_WIDTH)'(w_p1[j]);
    end
  end

  // ---- p2: lane accumulation, qualified by the delayed read enable ----
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_acc) begin
      for (int j = 0; j < OUT_CH; j++)
        acc_p2[j] <= '0;
    end else if (vld_p1) begin
      for (int j = 0; j < OUT_CH; j++)
        acc_p2[j] <= acc_p2[j] + ACC_W'(prod_p1[j]);
    end
  end

  // ---- p3: requantise, ReLU, saturate into the output register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_o <= '0;
    end else if (state == QUANT) begin
      for (int j = 0; j < OUT_CH; j++)
        out_data_o[j*DATA_WIDTH +: DATA_WIDTH] <= sat_relu(rescale(acc_p2[j]), relu_q);
    end
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
module tb_fc_layer_engine;

  localparam int DW     = 8;
  localparam int IN_LEN = 4;
  localparam int OUT_CH = 2;
  localparam int NT     = 2;
  localparam int COEFF  = 3;
  localparam int SHIFT  = 2;
  localparam int MAXC   = 4 * (NT * (IN_LEN + 2) + IN_LEN);

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        relu_en_i;
  logic [1:0]  x_addr_o;
  logic        x_en_o;
  logic [7:0]  x_data_i;
  logic [2:0]  w_addr_o;
  logic        w_en_o;
  logic [15:0] w_data_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic [1:0]  out_tile_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  fc_layer_engine #(
    .DATA_WIDTH(DW), .IN_LEN(IN_LEN), .OUT_CH(OUT_CH), .NUM_TILES(NT),
    .COEFF_W(17), .COEFF(COEFF), .SHIFT(SHIFT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .relu_en_i(relu_en_i),
    .x_addr_o(x_addr_o), .x_en_o(x_en_o), .x_data_i(x_data_i),
    .w_addr_o(w_addr_o), .w_en_o(w_en_o), .w_data_i(w_data_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_tile_o(out_tile_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // External memories: one-cycle read latency, garbage when not enabled.
  logic signed [7:0] xmem [IN_LEN];
  logic signed [7:0] wmem [IN_LEN*NT][OUT_CH];

  always @(posedge clk) begin
    if (x_en_o) x_data_i <= xmem[x_addr_o];
    else        x_data_i <= 8'($urandom);
    for (int j = 0; j < OUT_CH; j++) begin
      if (w_en_o) w_data_i[j*8 +: 8] <= wmem[w_addr_o][j];
      else        w_data_i[j*8 +: 8] <= 8'($urandom);
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: dot products with plain integers, then requantise.
  function automatic logic [7:0] ref_quant(input longint acc, input logic relu);
    longint p, r;
    p = acc * COEFF;
    r = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (relu && r < 0) r = 0;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  function automatic logic [15:0] model_tile(input int t, input logic relu);
    logic [15:0] res;
    longint acc;
    for (int j = 0; j < OUT_CH; j++) begin
      acc = 0;
      for (int kk = 0; kk < IN_LEN; kk++)
        acc += longint'(xmem[kk]) * longint'(wmem[t*IN_LEN + kk][j]);
      res[j*8 +: 8] = ref_quant(acc, relu);
    end
    return res;
  endfunction

  task automatic load_random();
    for (int kk = 0; kk < IN_LEN; kk++) xmem[kk] = 8'($urandom);
    for (int a = 0; a < IN_LEN*NT; a++)
      for (int j = 0; j < OUT_CH; j++) wmem[a][j] = 8'($urandom);
  endtask

  // Captured results of one run.
  logic [15:0] got_data [NT];
  logic [1:0]  got_tile [NT];
  int          got_cyc  [NT];
  int          nvalid, ndone, done_cyc;

  // Cycle 0 is the cycle in which start_i is sampled high. Returns at the
  // negedge of the done_o cycle (or after the cycle budget runs out).
  task automatic run_collect(input logic relu, input bit pre_started, input int poke_cyc);
    nvalid = 0; ndone = 0; done_cyc = -1;
    if (!pre_started) begin
      @(negedge clk); start_i = 1'b1; relu_en_i = relu;
      @(negedge clk); start_i = 1'b0;
    end
    for (int c = 1; c <= MAXC; c++) begin
      start_i = (c == poke_cyc);
      if (out_valid_o) begin
        if (nvalid < NT) begin
          got_data[nvalid] = out_data_o;
          got_tile[nvalid] = out_tile_o;
          got_cyc[nvalid]  = c;
        end
        nvalid++;
      end
      if (done_o) begin
        ndone++;
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  task automatic check_run(input string tag, input logic [NT-1:0][15:0] exp);
    chk({tag, " valid count"}, nvalid, NT);
    chk({tag, " done count"}, ndone, 1);
    chk({tag, " done cycle"}, done_cyc, (NT-1)*(IN_LEN+2) + IN_LEN + 3);
    for (int t = 0; t < NT && t < nvalid; t++) begin
      chk($sformatf("%s tile%0d data", tag, t), got_data[t], exp[t]);
      chk($sformatf("%s tile%0d index", tag, t), got_tile[t], t);
      chk($sformatf("%s tile%0d valid cycle", tag, t), got_cyc[t], t*(IN_LEN+2) + IN_LEN + 3);
    end
  endtask

  typedef struct packed {
    logic [3:0][7:0]      x;
    logic [1:0][1:0][7:0] w;   // [tile][lane], same weight for every k
    logic                 relu;
    logic [1:0][1:0][7:0] e;   // expected [tile][lane]
  } vec_t;

  function automatic vec_t mkvec(input int x0, x1, x2, x3, w00, w01, w10, w11,
                                 input logic relu, input int e00, e01, e10, e11);
    vec_t v;
    v.x[0] = 8'(x0); v.x[1] = 8'(x1); v.x[2] = 8'(x2); v.x[3] = 8'(x3);
    v.w[0][0] = 8'(w00); v.w[0][1] = 8'(w01); v.w[1][0] = 8'(w10); v.w[1][1] = 8'(w11);
    v.relu = relu;
    v.e[0][0] = 8'(e00); v.e[0][1] = 8'(e01); v.e[1][0] = 8'(e10); v.e[1][1] = 8'(e11);
    return v;
  endfunction

  vec_t vecs [8];
  logic [NT-1:0][15:0] ex;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    // COEFF=3, SHIFT=2: q(acc) = floor((3*acc + 2) / 4)
    vecs[0] = mkvec(1, 2, 3, 4,   1, -1, 2, 0,       1'b0,   8, -7, 15, 0);
    vecs[1] = mkvec(1, 2, 3, 4,   1, -1, 2, 0,       1'b1,   8,  0, 15, 0);
    vecs[2] = mkvec(127, 127, 127, 127, 127, 127, 127, 127, 1'b0, 127, 127, 127, 127);
    vecs[3] = mkvec(127, 127, 127, 127, -128, -128, -128, -128, 1'b0, -128, -128, -128, -128);
    vecs[4] = mkvec(127, 127, 127, 127, -128, -128, -128, -128, 1'b1, 0, 0, 0, 0);
    vecs[5] = mkvec(1, 1, 1, 2,   1, -1, 0, 2,       1'b0,   4, -4, 0, 8);
    vecs[6] = mkvec(1, 1, 0, 0,   1, -1, 3, -3,      1'b0,   2, -1, 5, -4);
    vecs[7] = mkvec(-128, -128, -128, -128, -128, -128, -128, -128, 1'b0, 127, 127, 127, 127);

    rst_i = 1'b1; start_i = 1'b0; relu_en_i = 1'b0;
    for (int kk = 0; kk < IN_LEN; kk++) xmem[kk] = '0;
    for (int a = 0; a < IN_LEN*NT; a++)
      for (int j = 0; j < OUT_CH; j++) wmem[a][j] = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs",
        {x_en_o, w_en_o, x_addr_o, w_addr_o, out_valid_o, done_o, busy_o, out_tile_o, out_data_o}, 0);
    rst_i = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      for (int kk = 0; kk < IN_LEN; kk++) xmem[kk] = vecs[i].x[kk];
      for (int t = 0; t < NT; t++)
        for (int kk = 0; kk < IN_LEN; kk++)
          for (int j = 0; j < OUT_CH; j++) wmem[t*IN_LEN + kk][j] = vecs[i].w[t][j];
      for (int t = 0; t < NT; t++) ex[t] = vecs[i].e[t];
      run_collect(vecs[i].relu, 1'b0, 0);
      check_run($sformatf("vec%0d", i), ex);
    end

    // Cycle-by-cycle schedule of a two-tile run
    load_random();
    for (int t = 0; t < NT; t++) ex[t] = model_tile(t, 1'b0);
    @(negedge clk); start_i = 1'b1; relu_en_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      logic run_c;
      int kk, t;
      logic [1:0] ea;
      logic [2:0] ew;
      run_c = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      kk = (c <= 4) ? c - 1 : c - 7;
      t  = (c >= 7) ? 1 : 0;
      ea = run_c ? 2'(kk) : 2'd0;
      ew = run_c ? 3'(t*IN_LEN + kk) : 3'd0;
      chk($sformatf("schedule cycle %0d", c),
          {x_en_o, w_en_o, x_addr_o, w_addr_o, out_valid_o, done_o, busy_o},
          {run_c, run_c, ea, ew, (c == 7 || c == 13), (c == 13), (c >= 1 && c <= 12)});
      if (c == 7)  chk("schedule tile0 data", {out_tile_o, out_data_o}, {2'd0, ex[0]});
      if (c == 13) chk("schedule tile1 data", {out_tile_o, out_data_o}, {2'd1, ex[1]});
      @(negedge clk);
    end

    // start_i during RUN is ignored
    load_random();
    for (int t = 0; t < NT; t++) ex[t] = model_tile(t, 1'b1);
    run_collect(1'b1, 1'b0, 2);
    check_run("start in run", ex);

    // start_i in the done cycle begins a new run immediately
    load_random();
    for (int t = 0; t < NT; t++) ex[t] = model_tile(t, 1'b0);
    run_collect(1'b0, 1'b0, 0);
    check_run("before restart", ex);
    load_random();
    for (int t = 0; t < NT; t++) ex[t] = model_tile(t, 1'b1);
    start_i = 1'b1; relu_en_i = 1'b1;
    @(negedge clk); start_i = 1'b0; relu_en_i = 1'b0;
    chk("restart x_en/busy", {x_en_o, busy_o}, 2'b11);
    run_collect(1'b1, 1'b1, 0);
    check_run("restart", ex);

    // Reset during RUN at k=2
    load_random();
    @(negedge clk); start_i = 1'b1; relu_en_i = 1'b0;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset x_addr", x_addr_o, 2);
    rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    chk("mid-run reset outputs",
        {x_en_o, w_en_o, x_addr_o, w_addr_o, out_valid_o, done_o, busy_o, out_tile_o, out_data_o}, 0);
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 20; c++) begin
        if (out_valid_o || done_o || busy_o) stray++;
        @(negedge clk);
      end
      chk("activity after reset", stray, 0);
    end
    load_random();
    for (int t = 0; t < NT; t++) ex[t] = model_tile(t, 1'b0);
    run_collect(1'b0, 1'b0, 0);
    check_run("after reset", ex);

    // Randomized runs against the reference model
    for (int i = 0; i < 12; i++) begin
      logic r;
      load_random();
      r = 1'($urandom);
      for (int t = 0; t < NT; t++) ex[t] = model_tile(t, r);
      run_collect(r, 1'b0, 0);
      check_run($sformatf("rand%0d", i), ex);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
